// File: rtl/pt_write_sink.sv
// Pixel write sink: takes transform-stage pixel writes, converts (x,y) to a
// linear word address, queues them in a first-word-fall-through FIFO and
// presents the head entry to the memory arbiter. The FIFO also tracks drops
// and flags the last pixel of the frame.
module pt_write_sink #(
  parameter int          DEPTH     = 8,
  parameter logic [18:0] BASE_ADDR = 19'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] pt_pixel_write,
  input  logic [9:0]  pt_x,
  input  logic [8:0]  pt_y,
  input  logic        pt_wr,
  output logic        ptflag,
  output logic [18:0] mem_addr,
  output logic [17:0] mem_data,
  output logic        mem_we,
  input  logic        mem_grant,
  output logic        frame_done,
  output logic [7:0]  drop_count,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        last;
    logic [18:0] addr;
    logic [17:0] data;
  } entry_t;

  entry_t          fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  entry_t          head, push_entry;
  logic            in_range, accept, push, pop, range_drop, ovf_drop;
  logic [18:0]     y_ext, push_addr;

  // Request qualification and address formation (y*640 = y*512 + y*128).
  always_comb begin
    in_range   = (pt_x < 10'd640) && (pt_y < 9'd480);
    accept     = pt_wr & ptflag;
    push       = accept & in_range;
    range_drop = accept & ~in_range;
    ovf_drop   = pt_wr & ~ptflag;
    pop        = mem_we & mem_grant;
    y_ext      = {10'b0, pt_y};
    push_addr  = BASE_ADDR + (y_ext << 9) + (y_ext << 7) + {9'b0, pt_x};
    push_entry = '{last: (pt_x == 10'd639) && (pt_y == 9'd479),
                   addr: push_addr, data: pt_pixel_write};
  end

  // Occupancy after this edge; push and pop together cancel out.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Head entry is visible whenever the FIFO holds anything; zero otherwise.
  always_comb begin
    head     = fifo_mem[rd_ptr];
    mem_we   = (count != '0);
    mem_addr = mem_we ? head.addr : '0;
    mem_data = mem_we ? head.data : '0;
  end

  // Entry storage; not reset since only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  // Pointers, occupancy, registered ready flag and frame-end pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ptflag     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      ptflag     <= (count_nxt < CW'(DEPTH));
      frame_done <= pop & head.last;
    end
  end

  // Drop accounting: saturating counter plus sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if ((range_drop | ovf_drop) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
      if (ovf_drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pt_write_sink.sv
// Bench for pt_write_sink: directed scenarios plus a randomized run, all
// checked against a queue-based model of the sink.
module tb_pt_write_sink;

  localparam int          DEPTH = 8;
  localparam logic [18:0] BASE  = 19'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] pt_pixel_write = '0;
  logic [9:0]  pt_x = '0;
  logic [8:0]  pt_y = '0;
  logic        pt_wr = 1'b0;
  logic        ptflag;
  logic [18:0] mem_addr;
  logic [17:0] mem_data;
  logic        mem_we;
  logic        mem_grant = 1'b0;
  logic        frame_done;
  logic [7:0]  drop_count;
  logic        overflow;

  pt_write_sink #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .pt_pixel_write(pt_pixel_write),
    .pt_x(pt_x), .pt_y(pt_y), .pt_wr(pt_wr), .ptflag(ptflag),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_grant(mem_grant), .frame_done(frame_done),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  typedef struct {
    logic [18:0] addr;
    logic [17:0] data;
    logic        last;
  } ent_t;
  ent_t q[$];
  bit   m_ptflag;
  int   m_drop;
  bit   m_ovf;
  bit   m_fd;

  task automatic model_clear();
    q.delete();
    m_ptflag = 0; m_drop = 0; m_ovf = 0; m_fd = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // return #1 after the edge with inputs idled.
  task automatic tick(input bit wr, input logic [9:0] x, input logic [8:0] y,
                      input logic [17:0] pix, input bit g);
    bit   inr;
    int   a;
    ent_t e;
    pt_wr = wr; pt_x = x; pt_y = y; pt_pixel_write = pix; mem_grant = g;
    inr  = (int'(x) < 640) && (int'(y) < 480);
    m_fd = 0;
    if (g && q.size() > 0) begin
      m_fd = q[0].last;
      e = q.pop_front();
    end
    if (wr && m_ptflag && inr) begin
      a = int'(BASE) + int'(y) * 640 + int'(x);
      e.addr = a[18:0];
      e.data = pix;
      e.last = (int'(x) == 639) && (int'(y) == 479);
      q.push_back(e);
    end
    if (wr && !m_ptflag) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end else if (wr && !inr) begin
      if (m_drop < 255) m_drop++;
    end
    m_ptflag = (q.size() < DEPTH);
    @(posedge clk);
    #1;
    pt_wr = 0; mem_grant = 0;
  endtask

  task automatic apply_reset();
    pt_wr = 0; mem_grant = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    tick(0, 0, 0, 0, 0);
  endtask

  function automatic logic [9:0] rand_x();
    return ($urandom_range(0, 9) == 0) ? 10'($urandom_range(640, 1023))
                                       : 10'($urandom_range(0, 639));
  endfunction
  function automatic logic [8:0] rand_y();
    return ($urandom_range(0, 9) == 0) ? 9'($urandom_range(480, 511))
                                       : 9'($urandom_range(0, 479));
  endfunction

  task automatic test_reset();
    reset = 1;
    @(posedge clk); #1;
    vectors++;
    if ({mem_we, ptflag, frame_done, overflow} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got we/flag/fd/ovf=%b expected 0000",
               {mem_we, ptflag, frame_done, overflow});
    end
    vectors++;
    if (mem_addr !== 19'd0 || mem_data !== 18'd0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%0d data=%h drop=%0d expected 0",
               mem_addr, mem_data, drop_count);
    end
    reset = 0;
    #2;
    vectors++;
    if (ptflag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_flag: got %b expected 0", ptflag);
    end
    model_clear();
    tick(0, 0, 0, 0, 0);
    vectors++;
    if (ptflag !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_edge_flag: got %b expected 1", ptflag);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    tick(1, 10'd3, 9'd2, 18'h2A5A, 0);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 19'd1283 || mem_data !== 18'h2A5A) begin
      miscompares++;
      $display("FAIL basic_head: got we=%b addr=%0d data=%h expected 1 1283 2a5a",
               mem_we, mem_addr, mem_data);
    end
    tick(0, 0, 0, 0, 1);
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_popped: got we=%b expected 0", mem_we);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 8; i++)
      tick(1, 10'($urandom_range(0, 639)), 9'($urandom_range(0, 479)),
           18'($urandom), 0);
    vectors++;
    if (ptflag !== 1'b0) begin
      miscompares++;
      $display("FAIL full_flag: got ptflag=%b expected 0", ptflag);
    end
    tick(1, 10'd5, 9'd5, 18'h3FFFF, 0);
    vectors++;
    if (drop_count !== 8'd1 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_drop: got drop=%0d ovf=%b expected 1 1",
               drop_count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== q[0].addr || mem_data !== q[0].data) begin
        miscompares++;
        $display("FAIL drain_order[%0d]: got we=%b addr=%0d data=%h expected 1 %0d %h",
                 i, mem_we, mem_addr, mem_data, q[0].addr, q[0].data);
      end
      tick(0, 0, 0, 0, 1);
    end
    vectors++;
    if (mem_we !== 1'b0 || ptflag !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_empty: got we=%b flag=%b expected 0 1", mem_we, ptflag);
    end
  endtask

  task automatic test_range();
    apply_reset();
    tick(1, 10'd640, 9'd0, 18'h1, 0);
    tick(1, 10'd0, 9'd480, 18'h2, 0);
    vectors++;
    if (mem_we !== 1'b0 || drop_count !== 8'd2 || ptflag !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL range_drop: got we=%b drop=%0d flag=%b ovf=%b expected 0 2 1 0",
               mem_we, drop_count, ptflag, overflow);
    end
  endtask

  task automatic test_frame_done();
    apply_reset();
    tick(1, 10'd639, 9'd479, 18'h155AA, 0);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 19'd307199 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL last_head: got we=%b addr=%0d fd=%b expected 1 307199 0",
               mem_we, mem_addr, frame_done);
    end
    tick(0, 0, 0, 0, 1);
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_done_pulse: got %b expected 1", frame_done);
    end
    tick(0, 0, 0, 0, 0);
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_done_width: got %b expected 0", frame_done);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 4; i++)
      tick(1, 10'($urandom_range(0, 639)), 9'($urandom_range(0, 479)),
           18'($urandom), 0);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== q[0].addr || mem_data !== q[0].data
          || ptflag !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_order[%0d]: got addr=%0d data=%h flag=%b expected %0d %h 1",
                 i, mem_addr, mem_data, ptflag, q[0].addr, q[0].data);
      end
      tick(1, 10'($urandom_range(0, 639)), 9'($urandom_range(0, 479)),
           18'($urandom), 1);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== q[0].addr) begin
        miscompares++;
        $display("FAIL b2b_tail[%0d]: got we=%b addr=%0d expected 1 %0d",
                 i, mem_we, mem_addr, q[0].addr);
      end
      tick(0, 0, 0, 0, 1);
    end
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_occupancy: entries remain, we=%b expected 0", mem_we);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++)
      tick(1, 10'($urandom_range(0, 639)), 9'($urandom_range(0, 479)),
           18'($urandom), 0);
    reset = 1;
    #1;
    vectors++;
    if (mem_we !== 1'b0 || ptflag !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async: got we=%b flag=%b expected 0 0", mem_we, ptflag);
    end
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    vectors++;
    if (ptflag !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_release: got flag=%b we=%b expected 0 0", ptflag, mem_we);
    end
    tick(0, 0, 0, 0, 1);
    vectors++;
    if (ptflag !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_flag_rise: got %b expected 1", ptflag);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 1);
      vectors++;
      if (mem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_stale[%0d]: got we=%b expected 0", i, mem_we);
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 270; i++) tick(1, 10'd1, 9'd1, 18'($urandom), 0);
    vectors++;
    if (drop_count !== 8'd255 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_saturate: got drop=%0d ovf=%b expected 255 1",
               drop_count, overflow);
    end
  endtask

  task automatic test_random();
    bit          wr, g;
    logic [9:0]  x;
    logic [8:0]  y;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      wr = ($urandom_range(0, 9) < 7);
      g  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 29) == 0) begin
        x = 10'd639; y = 9'd479;
      end else begin
        x = rand_x(); y = rand_y();
      end
      tick(wr, x, y, 18'($urandom), g);
      vectors++;
      if (mem_we !== (q.size() != 0) || ptflag !== m_ptflag
          || drop_count !== 8'(m_drop) || overflow !== m_ovf
          || frame_done !== m_fd) begin
        miscompares++;
        $display("FAIL rand_ctrl[%0d]: got we=%b flag=%b drop=%0d ovf=%b fd=%b expected %b %b %0d %b %b",
                 i, mem_we, ptflag, drop_count, overflow, frame_done,
                 (q.size() != 0), m_ptflag, m_drop, m_ovf, m_fd);
      end
      if (q.size() != 0) begin
        vectors++;
        if (mem_addr !== q[0].addr || mem_data !== q[0].data) begin
          miscompares++;
          $display("FAIL rand_head[%0d]: got addr=%0d data=%h expected %0d %h",
                   i, mem_addr, mem_data, q[0].addr, q[0].data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_range();
    test_frame_done();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pt_write_sink.md
PT_WRITE_SINK -- requirements
Module: pt_write_sink

Interface
REQ-001: Parameter DEPTH, 8, FIFO entries (power of two, 2..32).
REQ-002: Parameter BASE_ADDR, 19'd0, memory word address of pixel (0,0).
REQ-003: Port clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004: Port reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005: Port pt_pixel_write  input  18  pixel data from the transform stage.
REQ-006: Port pt_x  input  10  destination column; pt_y  input  9  destination row.
REQ-007: Port pt_wr  input  1  write request, one cycle per pixel.
REQ-008: Port ptflag  output  1  "okay to send"; high means the next pt_wr is accepted.
REQ-009: Port mem_addr  output  19  word address of the head entry.
REQ-010: Port mem_data  output  18  pixel of the head entry.
REQ-011: Port mem_we  output  1  write request to the memory arbiter.
REQ-012: Port mem_grant  input  1  arbiter accepts the head entry on this edge.
REQ-013: Port frame_done  output  1  one-cycle pulse, last pixel of frame written.
REQ-014: Port drop_count  output  8  saturating count of discarded requests.
REQ-015: Port overflow  output  1  sticky; a request arrived while ptflag was low.

Function
REQ-016: Accept = pt_wr & ptflag at a clock edge; an accepted request SHALL be pushed to the FIFO on that edge if in range.
REQ-017: In range = pt_x < 640 and pt_y < 480; out-of-range accepted requests SHALL NOT be pushed and SHALL increment drop_count.
REQ-018: Pushed address = BASE_ADDR + pt_y*640 + pt_x, computed as (y<<9)+(y<<7)+x, mod 2^19.
REQ-019: pt_wr with ptflag low SHALL be discarded, SHALL increment drop_count, and SHALL set overflow.
REQ-020: drop_count SHALL saturate at 255; a range drop and an overflow drop never occur in the same cycle.
REQ-021: ptflag SHALL be registered: next value = (next occupancy < DEPTH).
REQ-022: mem_we SHALL equal FIFO non-empty; mem_addr/mem_data SHALL present the head entry (first-word-fall-through).
REQ-023: Latency: a request accepted at edge N SHALL appear at the head at earliest after edge N (mem_we high in cycle N+1) if the FIFO was empty.
REQ-024: Head SHALL be popped at an edge where mem_we & mem_grant; mem_addr/mem_data SHALL hold stable while mem_we high and mem_grant low.
REQ-025: mem_grant while mem_we low SHALL be ignored.
REQ-026: Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; when full, push is blocked by ptflag even if a pop occurs the same cycle.
REQ-027: Read/write pointers SHALL wrap modulo DEPTH; occupancy counter SHALL range 0..DEPTH.
REQ-028: frame_done SHALL pulse high for the cycle after the pop of an entry whose source coordinates were (639,479); the FIFO SHALL carry a 1-bit last flag per entry for this.
REQ-029: Entries SHALL be written to memory in acceptance order, none duplicated or lost except per REQ-017/019.

Reset
REQ-030: While reset is high: FIFO empty, pointers 0, ptflag 0, mem_we 0, mem_addr 0, mem_data 0, frame_done 0, drop_count 0, overflow 0.
REQ-031: ptflag SHALL rise on the first clock edge after reset deasserts.
REQ-032: Reset asserted mid-operation SHALL discard all queued entries immediately; no mem_we after reset asserts.

Verification
REQ-033: After reset, pt_wr with x=3,y=2,pixel=18'h2A5A -> next cycle mem_we=1, mem_addr=1283, mem_data=18'h2A5A; grant -> mem_we=0.
REQ-034: mem_grant held low, 8 consecutive writes -> ptflag low after 8th accept; 9th pt_wr -> drop_count=1, overflow=1; then grants -> 8 writes in order.
REQ-035: pt_wr with x=640,y=0 and with x=0,y=480 -> no mem_we, drop_count=2, ptflag stays 1.
REQ-036: Write (639,479) granted -> frame_done high exactly one cycle after grant edge, mem_addr was 307199.
REQ-037: FIFO at 4 entries, push and grant same edge every cycle for 20 cycles -> occupancy stays 4, order preserved.
REQ-038: Reset pulsed with 5 entries queued -> mem_we 0 during reset, ptflag 0, then 1 one edge after release, no stale writes.
